// File: rtl/fft_agu.sv
// fft_agu -- address generator for an in-place radix-2 FFT.
//
// For each pass the block walks LOG2N stages of N/2 butterflies. In each
// butterfly cycle it issues the two sample read addresses and the twiddle
// index. After PIPE_DEPTH cycles the matching write-back addresses appear on
// the write port. A stage's READ phase is followed by PIPE_DEPTH DRAIN cycles,
// so the last write of a stage lands before the first read of the next stage.
//
// Optional feature macro: FFT_AGU_LOAD_EN adds a LOAD phase before the
// butterflies. It accepts N samples and writes them to bit-reversed addresses.
//
// Ports:
//   clk                   rising-edge clock
//   reset                 synchronous, active-low reset
//   start                 request one pass (only sampled in IDLE)
//   load_valid            (FFT_AGU_LOAD_EN) sample available this cycle
//   load_addr, load_we    (FFT_AGU_LOAD_EN) bit-reversed load address / strobe
//   rd_addr_a, rd_addr_b  butterfly read addresses (0 when rd_en=0)
//   tw_addr               twiddle ROM index (0 when rd_en=0)
//   rd_en                 read addresses valid
//   wr_addr_a, wr_addr_b  write-back addresses (0 when wr_en=0)
//   wr_en                 write-back valid
//   busy, done            busy outside IDLE; done one-cycle completion pulse
//   dbg_state_o           current FSM state, for debug/checkers
//
// Handshake: there is no back-pressure. rd_en/wr_en/load_we are pure strobes,
// and each asserted cycle is exactly one transfer. load_valid=1 in LOAD is
// taken as an accepted sample that same cycle.
module fft_agu #(
    parameter int LOG2N      = 5,
    parameter int PIPE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef FFT_AGU_LOAD_EN
    input  logic             load_valid,
    output logic [LOG2N-1:0] load_addr,
    output logic             load_we,
`endif
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             rd_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic             wr_en,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state_o
);

    localparam int N    = 2 ** LOG2N;
    localparam int HALF = N / 2;
    localparam int IW   = LOG2N - 1;
    localparam int SW   = $clog2(LOG2N);
    localparam int DW   = $clog2(PIPE_DEPTH + 1);
    localparam int PW   = 2 * LOG2N + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_FIN   = 3'd3,
        S_LOAD  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [SW-1:0]    s_q, s_d;
    logic [DW-1:0]    d_q, d_d;
    logic [LOG2N-1:0] ld_q, ld_d;
    logic [PW-1:0]    pipe_q [PIPE_DEPTH];

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            s_q     <= '0;
            d_q     <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            s_q     <= s_d;
            d_q     <= d_d;
            ld_q    <= ld_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        s_d     = s_q;
        d_d     = d_q;
        ld_d    = ld_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d  = '0;
                    s_d  = '0;
                    ld_d = '0;
`ifdef FFT_AGU_LOAD_EN
                    state_d = S_LOAD;
`else
                    state_d = S_READ;
`endif
                end
            end
`ifdef FFT_AGU_LOAD_EN
            S_LOAD: begin
                if (load_valid) begin
                    if (ld_q == LOG2N'(N - 1)) begin
                        ld_d    = '0;
                        state_d = S_READ;
                    end else begin
                        ld_d = ld_q + LOG2N'(1);
                    end
                end
            end
`endif
            S_READ: begin
                if (i_q == IW'(HALF - 1)) begin
                    i_d     = '0;
                    d_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_DRAIN: begin
                if (d_q == DW'(PIPE_DEPTH - 1)) begin
                    d_d = '0;
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        s_d     = s_q + SW'(1);
                        i_d     = '0;
                        state_d = S_READ;
                    end
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            S_FIN: begin
                s_d     = '0;
                i_d     = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- address generation ----------------
    logic [LOG2N-1:0] i_ext, mask, addr_a, tw_full;

    always_comb begin
        i_ext = {1'b0, i_q};
        mask  = (LOG2N'(1) << s_q) - LOG2N'(1);
        // Insert a zero at bit s: bits above s move up by one, bits below stay.
        addr_a  = ((i_ext & ~mask) << 1) | (i_ext & mask);
        tw_full = (i_ext & mask) << (SW'(LOG2N - 1) - s_q);

        rd_en     = (state_q == S_READ);
        rd_addr_a = rd_en ? addr_a : '0;
        rd_addr_b = rd_en ? (addr_a | (LOG2N'(1) << s_q)) : '0;
        tw_addr   = rd_en ? tw_full[LOG2N-2:0] : '0;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        dbg_state_o = state_q;
    end

`ifdef FFT_AGU_LOAD_EN
    always_comb begin
        load_we   = (state_q == S_LOAD) && load_valid;
        load_addr = '0;
        if (load_we) begin
            for (int k = 0; k < LOG2N; k++) begin
                load_addr[k] = ld_q[LOG2N-1-k];
            end
        end
    end
`endif

    // ---------------- write-back delay line ----------------
    // Entry layout {en, a, b}. Idle read addresses are already 0, so idle
    // write addresses come out as 0 without extra gating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign wr_en     = pipe_q[PIPE_DEPTH-1][PW-1];
    assign wr_addr_a = pipe_q[PIPE_DEPTH-1][PW-2:LOG2N];
    assign wr_addr_b = pipe_q[PIPE_DEPTH-1][LOG2N-1:0];

endmodule

// File: tb/tb_fft_agu.sv
module tb_fft_agu;

  localparam int LOG2N = 3;
  localparam int PD    = 2;
  localparam int N     = 8;
`ifdef FFT_AGU_LOAD_EN
  localparam int LOAD_CYC = N;
`else
  localparam int LOAD_CYC = 0;
`endif
  localparam int EXP_BUSY = LOG2N * (N / 2 + PD) + 1 + LOAD_CYC;

  logic       clk, reset, start;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic       rd_en, wr_en, busy, done;
  logic [2:0] dbg_state;
`ifdef FFT_AGU_LOAD_EN
  logic       load_valid, load_we;
  logic [2:0] load_addr;
`endif

  fft_agu #(.LOG2N(LOG2N), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef FFT_AGU_LOAD_EN
    .load_valid(load_valid), .load_addr(load_addr), .load_we(load_we),
`endif
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .rd_en(rd_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_en(wr_en), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic h1 = 1'b0, h2 = 1'b0;
  logic [7:0] exp_rd_q[$];
  logic [5:0] exp_wr_q[$];

  // Hand-computed (a, b, tw) for N=8, packed as {a[2:0], b[2:0], tw[1:0]}.
  logic [7:0] rd_tab [12] = '{
    {3'd0, 3'd1, 2'd0}, {3'd2, 3'd3, 2'd0}, {3'd4, 3'd5, 2'd0}, {3'd6, 3'd7, 2'd0},
    {3'd0, 3'd2, 2'd0}, {3'd1, 3'd3, 2'd2}, {3'd4, 3'd6, 2'd0}, {3'd5, 3'd7, 2'd2},
    {3'd0, 3'd4, 2'd0}, {3'd1, 3'd5, 2'd1}, {3'd2, 3'd6, 2'd2}, {3'd3, 3'd7, 2'd3}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pass();
    for (int k = 0; k < 12; k++) begin
      exp_rd_q.push_back(rd_tab[k]);
      exp_wr_q.push_back(rd_tab[k][7:2]);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_rd"}, {rd_en, rd_addr_a, rd_addr_b, tw_addr}, 0);
    check({name, "_wr"}, {wr_en, wr_addr_a, wr_addr_b}, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns at the FIN->IDLE edge plus #1.
  task automatic wait_done(input string name);
    int target;
    int n;
    target = done_cnt + 1;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt < target) check({name, "_timeout"}, 0, 1);
    check({name, "_busy_after"}, busy, 0);
  endtask

  // ---------------- monitor ----------------
`ifdef FFT_AGU_LOAD_EN
  logic [2:0] ld_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  int ld_idx = 0;
`endif

  always @(negedge clk) begin
    logic [7:0] e;
    logic [5:0] w;
    if (!reset) begin
      h1 = 1'b0;
      h2 = 1'b0;
      busy_cnt = 0;
`ifdef FFT_AGU_LOAD_EN
      ld_idx = 0;
`endif
    end else begin
      check("wr_en_delay", wr_en, h2);
      h2 = h1;
      h1 = rd_en;
      if (rd_en) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = exp_rd_q.pop_front();
          check("rd_addr_a", rd_addr_a, e[7:5]);
          check("rd_addr_b", rd_addr_b, e[4:2]);
          check("tw_addr", tw_addr, e[1:0]);
        end
      end else begin
        check("rd_idle_zero", {rd_addr_a, rd_addr_b, tw_addr}, 0);
      end
      if (wr_en) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = exp_wr_q.pop_front();
          check("wr_addr_a", wr_addr_a, w[5:3]);
          check("wr_addr_b", wr_addr_b, w[2:0]);
        end
      end else begin
        check("wr_idle_zero", {wr_addr_a, wr_addr_b}, 0);
      end
`ifdef FFT_AGU_LOAD_EN
      if (load_we) begin
        check("load_addr", load_addr, ld_tab[ld_idx]);
        ld_idx = (ld_idx + 1) % 8;
      end
`endif
      if (busy) busy_cnt++;
      else busy_cnt = 0;
      if (done) begin
        done_cnt++;
        check("done_cycle", busy_cnt, EXP_BUSY);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    reset = 1'b0;
    start = 1'b1;  // start coincident with reset must be ignored
`ifdef FFT_AGU_LOAD_EN
    load_valid = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_quiet("idle");

    // Pass 1: full pass from a single start pulse.
    push_pass();
    pulse_start();
    wait_done("pass1");
    check("pass1_rd_left", exp_rd_q.size(), 0);
    check("pass1_wr_left", exp_wr_q.size(), 0);

    // Abort during stage 1 READ (stage 1, i=1).
    push_pass();
    pulse_start();
    repeat (7 + LOAD_CYC) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check_quiet("abort");
    reset = 1'b1;
    exp_rd_q.delete();
    exp_wr_q.delete();
    dc = done_cnt;
    repeat (30) @(posedge clk);
    #1 check("abort_no_done", done_cnt, dc);
    check_quiet("abort_idle");

    // Fresh start after abort replays the same sequence.
    push_pass();
    pulse_start();
    wait_done("replay");
    check("replay_rd_left", exp_rd_q.size(), 0);
    check("replay_wr_left", exp_wr_q.size(), 0);

    // start held high: one pass to FIN, one IDLE cycle, then a new pass.
    push_pass();
    push_pass();
    dc = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    wait_done("held1");
    check("held_idle_state", dbg_state, 0);
    @(posedge clk);
    #1 check("held_restart_busy", busy, 1);
    start = 1'b0;
    wait_done("held2");
    check("held_done_count", done_cnt - dc, 2);
    check("held_rd_left", exp_rd_q.size(), 0);
    check("held_wr_left", exp_wr_q.size(), 0);

    repeat (5) @(posedge clk);
    #1 check_quiet("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
